// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and byte/word helpers used by the key-schedule
// sequencer and its round-step datapath.
package aes_pkg;

    localparam int KEY_W     = 128;
    localparam int NUM_SLOTS = 11;
    localparam int SCHED_W   = NUM_SLOTS * KEY_W;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } aes_state_e;

    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] fn_sbox(input logic [7:0] b);
        return AES_SBOX[b];
    endfunction

    function automatic logic [31:0] fn_sub_word(input logic [31:0] w);
        return {fn_sbox(w[31:24]), fn_sbox(w[23:16]), fn_sbox(w[15:8]), fn_sbox(w[7:0])};
    endfunction

    // Byte 0 sits in the top byte, so a left rotate by one byte moves it to the bottom.
    function automatic logic [31:0] fn_rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] fn_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round: derives round key r from round key r-1 and that round's rcon.
module aes_key_round_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] prev_key_i,
    input  logic [7:0]       rcon_i,
    output logic [KEY_W-1:0] next_key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        {w0, w1, w2, w3} = prev_key_i;
        n0 = w0 ^ fn_sub_word(fn_rot_word(w3)) ^ {rcon_i, 24'h0};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one shared round-step unit fills the 11-slot
// schedule over 10 cycles, then holds it valid with a generation tag and a registered read port.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int GEN_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_key_valid,
    input  logic [KEY_W-1:0]   i_key,
    output logic               o_key_ready,
    output logic               o_busy,
    output logic               o_sched_valid,
    output logic [SCHED_W-1:0] o_key_schedule,
    output logic [GEN_W-1:0]   o_sched_gen,
    input  logic [3:0]         i_rk_idx,
    output logic [KEY_W-1:0]   o_round_key
);

    aes_state_e       state_q;
    logic [3:0]       cnt_q;
    logic [7:0]       rcon_q;
    logic [7:0]       rcon_d;
    logic [KEY_W-1:0] sched_q [NUM_SLOTS];
    logic [GEN_W-1:0] gen_q;
    logic             valid_q;
    logic [KEY_W-1:0] rk_q;
    logic [KEY_W-1:0] rk_d;
    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;

    aes_key_round_step u_step (
        .prev_key_i (prev_key),
        .rcon_i     (rcon_q),
        .next_key_o (next_key)
    );

    always_comb begin
        prev_key = (cnt_q != 4'd0) ? sched_q[cnt_q - 4'd1] : sched_q[0];
        rcon_d   = fn_xtime(rcon_q);
        rk_d     = (i_rk_idx < 4'(NUM_SLOTS)) ? sched_q[i_rk_idx] : '0;
    end

    // Slot 0 occupies the most significant 128 bits, matching the big-endian byte order of the key.
    always_comb begin
        o_key_schedule = '0;
        for (int r = 0; r < NUM_SLOTS; r++) begin
            o_key_schedule[SCHED_W-1-KEY_W*r -: KEY_W] = sched_q[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rcon_q  <= 8'h01;
            gen_q   <= '0;
            valid_q <= 1'b0;
            rk_q    <= '0;
            for (int r = 0; r < NUM_SLOTS; r++) begin
                sched_q[r] <= '0;
            end
        end else begin
            rk_q <= rk_d;
            unique case (state_q)
                IDLE, DONE: begin
                    if (i_key_valid) begin
                        state_q    <= EXPAND;
                        sched_q[0] <= i_key;
                        cnt_q      <= 4'd1;
                        rcon_q     <= 8'h01;
                        valid_q    <= 1'b0;
                    end
                end
                EXPAND: begin
                    sched_q[cnt_q] <= next_key;
                    cnt_q          <= cnt_q + 4'd1;
                    rcon_q         <= rcon_d;
                    if (cnt_q == 4'(NUM_ROUNDS)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        gen_q   <= gen_q + GEN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_key_ready   = (state_q != EXPAND);
    assign o_busy        = (state_q == EXPAND);
    assign o_sched_valid = valid_q;
    assign o_sched_gen   = gen_q;
    assign o_round_key   = rk_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Randomized bench for aes_key_sched_ctrl, checked against a FIPS-197 word-array key expansion
// whose S-box is rebuilt from GF(2^8) inversion plus the affine transform.
module tb_aes_key_sched_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          keyValid;
    logic [127:0]  key;
    logic          keyReady;
    logic          busy;
    logic          schedValid;
    logic [1407:0] keySchedule;
    logic [3:0]    schedGen;
    logic [3:0]    rkIdx;
    logic [127:0]  roundKey;

    logic [7:0]    sboxTab [256];
    logic [127:0]  expSched [11];
    int            checks   = 0;
    int            failures = 0;
    int            expGen   = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NUM_ROUNDS(10), .GEN_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_key_valid    (keyValid),
        .i_key          (key),
        .o_key_ready    (keyReady),
        .o_busy         (busy),
        .o_sched_valid  (schedValid),
        .o_key_schedule (keySchedule),
        .o_sched_gen    (schedGen),
        .i_rk_idx       (rkIdx),
        .o_round_key    (roundKey)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook FIPS-197 expansion over 44 words with a literal rcon table.
    task automatic computeSchedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc [10];
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
                t = t ^ {rc[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) expSched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkSchedule(input string tag);
        for (int r = 0; r < 11; r++) begin
            checkOutput($sformatf("%s_slot%0d", tag, r), keySchedule[1407-128*r -: 128], expSched[r]);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, 128'(keyReady), 128'd1);
        checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
        checkOutput({tag, "_valid"}, 128'(schedValid), 128'd0);
        checkOutput({tag, "_gen"}, 128'(schedGen), 128'd0);
        checkOutput({tag, "_rdkey"}, roundKey, 128'h0);
        for (int r = 0; r < 11; r++) expSched[r] = 128'h0;
        checkSchedule(tag);
    endtask

    // Offers a key for exactly one edge; the DUT must be idle or done so it accepts immediately.
    task automatic applyStimulus(input logic [127:0] k);
        key      = k;
        keyValid = 1'b1;
        @(posedge clk);
        #1;
        keyValid = 1'b0;
        checkOutput("acc_busy", 128'(busy), 128'd1);
        checkOutput("acc_valid", 128'(schedValid), 128'd0);
    endtask

    task automatic waitSchedule(input logic [127:0] k, input int startLat);
        int lat = startLat;
        while (!schedValid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 128'(lat), 128'd11);
        expGen = (expGen + 1) % 16;
        checkOutput("gen", 128'(schedGen), 128'(expGen));
        checkOutput("done_ready", 128'(keyReady), 128'd1);
        checkOutput("done_busy", 128'(busy), 128'd0);
        computeSchedule(k);
        checkSchedule("sched");
    endtask

    task automatic runKey(input logic [127:0] k);
        applyStimulus(k);
        waitSchedule(k, 1);
    endtask

    function automatic logic [127:0] randKey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] keyB;
        logic [127:0] expRd;
        buildSbox();
        rst      = 1'b1;
        keyValid = 1'b0;
        key      = 128'h0;
        rkIdx    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("rst");

        // FIPS key accepted while a second key waits through the whole expansion.
        keyB     = randKey();
        key      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keyValid = 1'b1;
        @(posedge clk);
        #1;
        key = keyB;
        for (int c = 0; c < 9; c++) begin
            checkOutput("hold_ready", 128'(keyReady), 128'd0);
            checkOutput("hold_busy", 128'(busy), 128'd1);
            @(posedge clk);
            #1;
        end
        waitSchedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 10);
        checkOutput("fips_slot1", keySchedule[1279 -: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("fips_slot10", keySchedule[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(posedge clk);
        #1;
        keyValid = 1'b0;
        checkOutput("held_acc_valid", 128'(schedValid), 128'd0);
        checkOutput("held_acc_busy", 128'(busy), 128'd1);
        waitSchedule(keyB, 1);

        // New key while DONE discards the old schedule.
        runKey(randKey());

        // Reset four edges into an expansion, with a key offered on the reset edge.
        applyStimulus(randKey());
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst      = 1'b1;
        keyValid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        keyValid = 1'b0;
        expGen   = 0;
        checkResetState("midrst");
        runKey(randKey());

        for (int i = 0; i < 16; i++) begin
            rkIdx = 4'(i);
            @(posedge clk);
            #1;
            if (i <= 10) expRd = expSched[i];
            else expRd = 128'h0;
            checkOutput($sformatf("rd_idx%0d", i), roundKey, expRd);
        end
        rkIdx = 4'd0;

        for (int n = 0; n < 17; n++) begin
            runKey(randKey());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
